// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defs (package)
//  Description : Shared opcode, ALU select and instruction-field definitions
//                plus the packed decode bundle carried from decode to execute.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_defs;

    // Major opcodes (iword[31:28])
    localparam logic [3:0] OP_ALUR  = 4'h0;
    localparam logic [3:0] OP_CMPR  = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h5;
    localparam logic [3:0] OP_BCOND = 4'h6;
    localparam logic [3:0] OP_ALUI  = 4'h8;
    localparam logic [3:0] OP_LW    = 4'h9;
    localparam logic [3:0] OP_CMPI  = 4'hA;
    localparam logic [3:0] OP_JAL   = 4'hB;

    // ALU operation selects
    localparam logic [5:0] ALU_ADD  = 6'h00;
    localparam logic [5:0] ALU_SUB  = 6'h01;
    localparam logic [5:0] ALU_AND  = 6'h04;
    localparam logic [5:0] ALU_OR   = 6'h05;
    localparam logic [5:0] ALU_XOR  = 6'h06;
    localparam logic [5:0] ALU_MVHI = 6'h0B;
    localparam logic [5:0] ALU_SLL  = 6'h0C;
    localparam logic [5:0] ALU_SRL  = 6'h0D;
    localparam logic [5:0] ALU_SRA  = 6'h0E;
    localparam logic [5:0] ALU_CMP  = 6'h10;
    localparam logic [5:0] ALU_JAL  = 6'h20;

    // Instruction field bit positions
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 28;
    localparam int FN_HI  = 27;
    localparam int FN_LO  = 24;
    localparam int RD_HI  = 23;
    localparam int RD_LO  = 20;
    localparam int RS_HI  = 19;
    localparam int RS_LO  = 16;
    localparam int RT_HI  = 15;
    localparam int RT_LO  = 12;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // Packed decode bundle
    typedef struct packed {
        logic [5:0]  opsel;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [31:0] imm;
        logic        use_imm;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        jal;
        logic        illegal;
    } dec_t;

    localparam int DEC_W = 57;

    // Arithmetic/logic function legality; MVHI exists only in the immediate form
    function automatic logic alu_fn_legal(input logic [3:0] fn, input logic is_imm);
        logic ok;
        case (fn)
            4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'hC, 4'hD, 4'hE: ok = 1'b1;
            4'hB:                                           ok = is_imm;
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Compare/branch condition legality: everything but 4 and C
    function automatic logic cmp_fn_legal(input logic [3:0] fn);
        return (fn != 4'h4) && (fn != 4'hC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decoder
//  Description : Combinational translation of a 32-bit instruction word into
//                the packed ALU select / control bundle.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_decoder
    import cpu_defs::*;
(
    input  logic [31:0] iword,
    output dec_t        bundle
);

    logic [3:0] op;
    logic [3:0] fn;

    assign op = iword[OP_HI:OP_LO];
    assign fn = iword[FN_HI:FN_LO];

    // Decode by major opcode; register fields and immediate always pass through
    always_comb begin
        bundle         = '0;
        bundle.rd      = iword[RD_HI:RD_LO];
        bundle.rs      = iword[RS_HI:RS_LO];
        bundle.rt      = iword[RT_HI:RT_LO];
        bundle.imm     = {{16{iword[IMM_HI]}}, iword[IMM_HI:IMM_LO]};
        case (op)
            OP_ALUR, OP_ALUI: begin
                if (alu_fn_legal(fn, op == OP_ALUI)) begin
                    bundle.opsel   = {2'b00, fn};
                    bundle.reg_we  = 1'b1;
                    bundle.use_imm = (op == OP_ALUI);
                end else begin
                    bundle.illegal = 1'b1;
                end
            end
            OP_CMPR, OP_CMPI: begin
                if (cmp_fn_legal(fn)) begin
                    bundle.opsel   = ALU_CMP | {2'b00, fn};
                    bundle.reg_we  = 1'b1;
                    bundle.use_imm = (op == OP_CMPI);
                end else begin
                    bundle.illegal = 1'b1;
                end
            end
            OP_BCOND: begin
                if (cmp_fn_legal(fn)) begin
                    bundle.opsel  = ALU_CMP | {2'b00, fn};
                    bundle.branch = 1'b1;
                end else begin
                    bundle.illegal = 1'b1;
                end
            end
            OP_LW: begin
                bundle.opsel   = ALU_ADD;
                bundle.use_imm = 1'b1;
                bundle.mem_re  = 1'b1;
                bundle.reg_we  = 1'b1;
            end
            OP_SW: begin
                bundle.opsel   = ALU_ADD;
                bundle.use_imm = 1'b1;
                bundle.mem_we  = 1'b1;
            end
            OP_JAL: begin
                bundle.opsel   = ALU_JAL;
                bundle.use_imm = 1'b1;
                bundle.reg_we  = 1'b1;
                bundle.jal     = 1'b1;
            end
            default: begin
                bundle.illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Registered decode stage with valid/ready handshake, a
//                main + skid buffer pair and a single-cycle flush.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_stage
    import cpu_defs::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_iword,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_opsel,
    output logic [3:0]      out_rd,
    output logic [3:0]      out_rs,
    output logic [3:0]      out_rt,
    output logic [31:0]     out_imm,
    output logic            out_use_imm,
    output logic            out_reg_we,
    output logic            out_mem_re,
    output logic            out_mem_we,
    output logic            out_branch,
    output logic            out_jal,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_pc
);

    dec_t            in_bundle;
    logic            in_fire;

    logic            m_valid_q, m_valid_d;
    dec_t            m_bundle_q, m_bundle_d;
    logic [PC_W-1:0] m_pc_q, m_pc_d;
    logic            s_valid_q, s_valid_d;
    dec_t            s_bundle_q, s_bundle_d;
    logic [PC_W-1:0] s_pc_q, s_pc_d;

    instr_decoder u_instr_decoder (
        .iword  (in_iword),
        .bundle (in_bundle)
    );

    // Acceptance depends only on skid occupancy, so in_ready is a flop output
    assign in_ready = ~s_valid_q;
    assign in_fire  = in_valid & ~s_valid_q;

    // Next-state for main/skid registers: skid drains first, stall spills to skid
    always_comb begin
        m_valid_d  = m_valid_q;
        m_bundle_d = m_bundle_q;
        m_pc_d     = m_pc_q;
        s_valid_d  = s_valid_q;
        s_bundle_d = s_bundle_q;
        s_pc_d     = s_pc_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || out_ready) begin
            if (s_valid_q) begin
                m_valid_d  = 1'b1;
                m_bundle_d = s_bundle_q;
                m_pc_d     = s_pc_q;
                s_valid_d  = 1'b0;
            end else begin
                m_valid_d = in_fire;
                if (in_fire) begin
                    m_bundle_d = in_bundle;
                    m_pc_d     = in_pc;
                end
            end
        end else if (in_fire) begin
            s_valid_d  = 1'b1;
            s_bundle_d = in_bundle;
            s_pc_d     = in_pc;
        end
    end

    // State registers with synchronous reset clearing data as well as valids
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q  <= 1'b0;
            m_bundle_q <= '0;
            m_pc_q     <= '0;
            s_valid_q  <= 1'b0;
            s_bundle_q <= '0;
            s_pc_q     <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_bundle_q <= m_bundle_d;
            m_pc_q     <= m_pc_d;
            s_valid_q  <= s_valid_d;
            s_bundle_q <= s_bundle_d;
            s_pc_q     <= s_pc_d;
        end
    end

    assign out_valid   = m_valid_q;
    assign out_opsel   = m_bundle_q.opsel;
    assign out_rd      = m_bundle_q.rd;
    assign out_rs      = m_bundle_q.rs;
    assign out_rt      = m_bundle_q.rt;
    assign out_imm     = m_bundle_q.imm;
    assign out_use_imm = m_bundle_q.use_imm;
    assign out_reg_we  = m_bundle_q.reg_we;
    assign out_mem_re  = m_bundle_q.mem_re;
    assign out_mem_we  = m_bundle_q.mem_we;
    assign out_branch  = m_bundle_q.branch;
    assign out_jal     = m_bundle_q.jal;
    assign out_illegal = m_bundle_q.illegal;
    assign out_pc      = m_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Directed self-checking bench for decode_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_iword;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opsel;
    logic [3:0]  out_rd;
    logic [3:0]  out_rs;
    logic [3:0]  out_rt;
    logic [31:0] out_imm;
    logic        out_use_imm;
    logic        out_reg_we;
    logic        out_mem_re;
    logic        out_mem_we;
    logic        out_branch;
    logic        out_jal;
    logic        out_illegal;
    logic [31:0] out_pc;

    int total = 0;
    int bad   = 0;

    decode_stage #(.PC_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_iword    (in_iword),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opsel   (out_opsel),
        .out_rd      (out_rd),
        .out_rs      (out_rs),
        .out_rt      (out_rt),
        .out_imm     (out_imm),
        .out_use_imm (out_use_imm),
        .out_reg_we  (out_reg_we),
        .out_mem_re  (out_mem_re),
        .out_mem_we  (out_mem_we),
        .out_branch  (out_branch),
        .out_jal     (out_jal),
        .out_illegal (out_illegal),
        .out_pc      (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle 1 time unit past the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] flags();
        return {out_use_imm, out_reg_we, out_mem_re, out_mem_we, out_branch, out_jal, out_illegal};
    endfunction

    // present one word with out_ready high and check the bundle after the edge
    task automatic send_check(input string tag, input logic [31:0] w, input logic [31:0] pc,
                              input logic [5:0] e_op, input logic [3:0] e_rd, input logic [3:0] e_rs,
                              input logic [3:0] e_rt, input logic [31:0] e_imm, input logic [6:0] e_fl);
        in_valid  = 1'b1;
        in_iword  = w;
        in_pc     = pc;
        out_ready = 1'b1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".opsel"}, 64'(out_opsel), 64'(e_op));
        chk({tag, ".regs"},  64'({out_rd, out_rs, out_rt}), 64'({e_rd, e_rs, e_rt}));
        chk({tag, ".imm"},   64'(out_imm), 64'(e_imm));
        chk({tag, ".flags"}, 64'(flags()), 64'(e_fl));
        chk({tag, ".pc"},    64'(out_pc), 64'(pc));
    endtask

    // flags order: use_imm reg_we mem_re mem_we branch jal illegal
    initial begin
        logic [31:0] w [4];
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_iword  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.opsel", 64'(out_opsel), 64'd0);
        chk("rst.pc", 64'(out_pc), 64'd0);
        reset = 1'b0;
        step();

        // decode table
        send_check("add",   32'h00312000, 32'h0000_1004, 6'h00, 4'h3, 4'h1, 4'h2, 32'h0000_2000, 7'b0100000);
        send_check("addi",  32'h8045FFFF, 32'h0000_1008, 6'h00, 4'h4, 4'h5, 4'hF, 32'hFFFF_FFFF, 7'b1100000);
        send_check("mvhi",  32'h8B601234, 32'h0000_100C, 6'h0B, 4'h6, 4'h0, 4'h1, 32'h0000_1234, 7'b1100000);
        send_check("jal",   32'hB0A20004, 32'h0000_1010, 6'h20, 4'hA, 4'h2, 4'h0, 32'h0000_0004, 7'b1100010);
        send_check("badop", 32'hF0000000, 32'h0000_1014, 6'h00, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 7'b0000001);
        send_check("cmp4",  32'h24000000, 32'h0000_1018, 6'h00, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 7'b0000001);
        send_check("aluB",  32'h0B000000, 32'h0000_101C, 6'h00, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 7'b0000001);
        send_check("lw",    32'h95432010, 32'h0000_1020, 6'h00, 4'h4, 4'h3, 4'h2, 32'h0000_2010, 7'b1110000);
        send_check("sw",    32'h50123008, 32'h0000_1024, 6'h00, 4'h1, 4'h2, 4'h3, 32'h0000_3008, 7'b1001000);
        send_check("bcond", 32'h63012FFC, 32'h0000_1028, 6'h13, 4'h0, 4'h1, 4'h2, 32'h0000_2FFC, 7'b0000100);
        send_check("cmpi",  32'hA5E1FF80, 32'h0000_102C, 6'h15, 4'hE, 4'h1, 4'hF, 32'hFFFF_FF80, 7'b1100000);
        step();
        chk("drain.valid", 64'(out_valid), 64'd0);

        // backpressure: four words, out_ready low for three cycles
        w[0] = 32'h00112000; w[1] = 32'h00212000; w[2] = 32'h00312000; w[3] = 32'h00412000;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_iword = w[0]; in_pc = 32'h100;
        step();
        chk("bp.c1.rd", 64'(out_rd), 64'd1);
        chk("bp.c1.in_ready", 64'(in_ready), 64'd1);
        in_iword = w[1]; in_pc = 32'h104;
        step();
        chk("bp.c2.in_ready", 64'(in_ready), 64'd0);
        chk("bp.c2.rd", 64'(out_rd), 64'd1);
        in_iword = w[2]; in_pc = 32'h108;
        step();
        chk("bp.c3.rd", 64'(out_rd), 64'd1);
        chk("bp.c3.pc", 64'(out_pc), 64'h100);
        chk("bp.c3.valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp.o1.rd", 64'(out_rd), 64'd2);
        chk("bp.o1.pc", 64'(out_pc), 64'h104);
        chk("bp.o1.in_ready", 64'(in_ready), 64'd1);
        step();
        chk("bp.o2.rd", 64'(out_rd), 64'd3);
        chk("bp.o2.pc", 64'(out_pc), 64'h108);
        in_iword = w[3]; in_pc = 32'h10C;
        step();
        chk("bp.o3.rd", 64'(out_rd), 64'd4);
        chk("bp.o3.pc", 64'(out_pc), 64'h10C);
        in_valid = 1'b0;
        step();
        chk("bp.end.valid", 64'(out_valid), 64'd0);

        // flush with main and skid full plus a pending input
        out_ready = 1'b0;
        in_valid  = 1'b1; in_iword = 32'h00512000; in_pc = 32'h200;
        step();
        in_iword = 32'h00612000; in_pc = 32'h204;
        step();
        chk("fl.full.in_ready", 64'(in_ready), 64'd0);
        in_iword = 32'h00712000; in_pc = 32'h208;
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl.valid", 64'(out_valid), 64'd0);
        chk("fl.in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl.stay_empty", 64'(out_valid), 64'd0);
        end
        // flush drops an input even while in_ready is high
        in_valid = 1'b1; in_iword = 32'h00812000; in_pc = 32'h20C;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl.drop_in", 64'(out_valid), 64'd0);

        // reset while stalled full
        out_ready = 1'b0;
        in_valid  = 1'b1; in_iword = 32'hB0A20004; in_pc = 32'h300;
        step();
        in_iword = 32'h8045FFFF; in_pc = 32'h304;
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr.valid", 64'(out_valid), 64'd0);
        chk("mr.in_ready", 64'(in_ready), 64'd1);
        chk("mr.fields", 64'({out_opsel, out_rd, out_rs, out_rt, flags()}), 64'd0);
        chk("mr.imm", 64'(out_imm), 64'd0);
        chk("mr.pc", 64'(out_pc), 64'd0);
        send_check("post_rst", 32'h00312000, 32'h0000_0400, 6'h00, 4'h3, 4'h1, 4'h2, 32'h0000_2000, 7'b0100000);
        step();
        chk("post_rst.drain", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Pipelined instruction-decode stage that turns a fetched 32-bit instruction word into the 6-bit ALU operation select and its control bundle, consumed by the execute-stage ALU. It sits between fetch and execute. Its output register carries a valid/ready handshake and a 2-entry skid buffer, so fetch and execute can each stall independently. It also supports a single-cycle flush for branch or jump redirects.

## Interface

Parameters:

- `PC_W`, 32: width of the carried program counter.

Ports:

- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: fetch presents an instruction.
- `in_ready`, output, 1: stage can accept an instruction this cycle.
- `in_iword`, input, 32: instruction word.
- `in_pc`, input, `PC_W`: address of `in_iword` plus 4.
- `flush`, input, 1: discard every held and incoming instruction.
- `out_valid`, output, 1: decoded bundle present.
- `out_ready`, input, 1: execute accepts the bundle.
- `out_opsel`, output, 6: ALU select.
- `out_rd`, output, 4: destination register index.
- `out_rs`, output, 4: first source register index.
- `out_rt`, output, 4: second source register index.
- `out_imm`, output, 32: sign-extended `iword[15:0]`.
- `out_use_imm`, output, 1: ALU B operand comes from `out_imm`.
- `out_reg_we`, output, 1: register write enable.
- `out_mem_re`, output, 1: memory read.
- `out_mem_we`, output, 1: memory write.
- `out_branch`, output, 1: conditional branch.
- `out_jal`, output, 1: jump-and-link.
- `out_illegal`, output, 1: undefined encoding.
- `out_pc`, output, `PC_W`: carried PC.

## Operation

Instruction fields:

- `op` = `[31:28]`, `fn` = `[27:24]`, `rd` = `[23:20]`, `rs` = `[19:16]`, `rt` = `[15:12]`, `imm` = `[15:0]`.

Decode by `op`:

- ALUR `4'h0`: opsel `{2'b00,fn}`; `reg_we`.
  - Legal `fn`: 0, 1, 4, 5, 6, C, D, E.
- ALUI `4'h8`: same as ALUR, plus `use_imm`.
  - Legal `fn`: 0, 1, 4, 5, 6, B, C, D, E. `fn=B` is MVHI.
- CMPR `4'h2`: opsel `{2'b01,fn}`; `reg_we`.
  - Legal `fn`: every value except 4 and C.
- CMPI `4'hA`: same as CMPR, plus `use_imm`.
- LW `4'h9`: opsel ADD (`6'h00`); `use_imm`, `mem_re`, `reg_we`.
- SW `4'h5`: opsel ADD; `use_imm`, `mem_we`.
  - `rt` field is the store-data register.
- BCOND `4'h6`: opsel `{2'b01,fn}` with the CMP legality rules; `branch`.
  - No `reg_we`; `imm` is the word offset.
- JAL `4'hB`: opsel `6'h20`; `use_imm`, `reg_we`, `jal`.

Illegal encodings:

- Any other `op`, or an illegal `fn`, produces opsel `6'h00` and `illegal=1`.
- `reg_we`, `mem_re`, `mem_we`, `branch` and `jal` are all 0.
- The bundle still flows downstream so execute can trap on it.

Fields and PC:

- `rd`, `rs`, `rt` and `imm` are always passed through unmodified, whatever the class.
- `imm` is sign-extended from bit 15.
- `out_pc` equals `in_pc` of the same instruction.

## Timing

Latency and handshake:

- Latency is 1 cycle: a word accepted at edge N appears on `out_*` after edge N.
- Handshake rule: a transfer occurs when valid and ready are both high. `out_*` stay stable while `out_valid & ~out_ready`.

Storage:

- Main register M plus skid register S, each with its own valid bit.
- `in_ready = ~S.valid`. It is registered, with no combinational path from `out_ready`.

Per-edge update, when not in reset and not flushing:

- If M is empty or `out_ready`: M loads S if S is valid (S empties), otherwise M loads the input on an input transfer.
- If M is full and `~out_ready` and an input transfer occurs: the input goes into S.
- Simultaneous output pop and input push while S is empty: M loads the input directly, giving 1 per cycle throughput.

Flush and reset:

- `flush`: both valid bits clear at the edge. An input presented in the same cycle is dropped, even though `in_ready` was high. `flush` overrides `out_ready`.
- `reset`: both valid bits clear, so `out_valid=0` and `in_ready=1` the cycle after.
- All `out_*` data and control fields reset to 0, with `out_opsel=6'h00`.
- Reset mid-stall discards held words.

## Structure

Shared package `cpu_defs` holds:

- Opcode constants: `OP_ALUR`, `OP_ALUI`, `OP_CMPR`, `OP_CMPI`, `OP_LW`, `OP_SW`, `OP_BCOND`, `OP_JAL`.
- The ALU opsel constants (ADD … JAL).
- Field bit positions.
- `DEC_W`, the packed bundle width.

Natural sub-module:

- `instr_decoder`: purely combinational, `iword` → packed bundle.
- `decode_stage` instantiates it once, on the input side, and stores packed bundles in M and S.

## Test plan

- Single ADD word: `0x00312000` with `out_ready=1`, accepted at edge N, must appear after edge N with `opsel=00`, `rd=3`, `rs=1`, `rt=2`, `reg_we=1`, `use_imm=0`.
- ADDI word: `0x8045FFFF` must give `imm=0xFFFFFFFF`, `use_imm=1`, `opsel=00`. MVHI word `0x8B601234` must give `opsel=0B`, `imm=0x00001234`.
- JAL word: `0xB0A20004` must give `opsel=20`, `rd=A`, `rs=2`, `imm=4`, `jal=1`, `reg_we=1`. Words `0xF0000000` and `0x24000000` must each give `illegal=1`, `opsel=00`, no enables.
- Backpressure: stream 4 words with `out_ready=0` for 3 cycles. `in_ready` must fall after 2 accepted words, and `out_*` must hold word 0 stable. When `out_ready=1` resumes, all 4 words must emerge in order with no loss or duplicates.
- Flush with M and S both full and a valid input present must yield `out_valid=0` and `in_ready=1` next cycle. None of the three words may ever appear.
- Assert `reset` mid-stream must leave all outputs 0 the next cycle. The first word after release must decode normally.
